// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FWFT FIFO with valid/ready ports, fill count, level flags and sticky errors
module fifo_sync_param #(
  parameter int WIDTH              = 32,
  parameter int DEPTH_LOG2         = 8,
  parameter int ALMOST_FULL_LEVEL  = 240,
  parameter int ALMOST_EMPTY_LEVEL = 16
) (
  input  logic                  i_clock,
  input  logic                  i_nReset,
  input  logic                  i_flush,
  input  logic                  i_clearErrors,
  input  logic [WIDTH-1:0]      i_writeData,
  input  logic                  i_writeValid,
  output logic                  o_writeReady,
  output logic [WIDTH-1:0]      o_readData,
  output logic                  o_readValid,
  input  logic                  i_readReady,
  output logic [DEPTH_LOG2:0]   o_fillCount,
  output logic                  o_almostFull,
  output logic                  o_almostEmpty,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  localparam logic [DEPTH_LOG2:0] LP_ONE = 1;
  localparam logic [DEPTH_LOG2:0] LP_AF  = (DEPTH_LOG2+1)'(ALMOST_FULL_LEVEL);
  localparam logic [DEPTH_LOG2:0] LP_AE  = (DEPTH_LOG2+1)'(ALMOST_EMPTY_LEVEL);
  localparam logic                LP_AF_RST = (LP_AF == '0);

  logic [WIDTH-1:0]    r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr, r_count;
  logic                r_almost_full, r_almost_empty, r_overflow, r_underflow;
  logic                w_full, w_empty, w_push, w_pop;
  logic [DEPTH_LOG2:0] w_count_nxt;

  // Extra pointer MSB separates full (MSB differs) from empty (pointers equal)
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
  assign w_push  = i_writeValid && !w_full;
  assign w_pop   = i_readReady && !w_empty;

  always_comb begin
    w_count_nxt = (w_push && !w_pop) ? r_count + LP_ONE :
                  (w_pop && !w_push) ? r_count - LP_ONE : r_count;
  end

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_almost_full  <= LP_AF_RST;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      // A flush swallows the concurrent write, so it never counts as an overflow
      r_overflow  <= (i_writeValid && w_full && !i_flush) || (r_overflow && !i_clearErrors);
      r_underflow <= (i_readReady && w_empty && !i_flush) || (r_underflow && !i_clearErrors);
      if (i_flush) begin
        r_wr_ptr       <= '0;
        r_rd_ptr       <= '0;
        r_count        <= '0;
        r_almost_full  <= LP_AF_RST;
        r_almost_empty <= 1'b1;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + LP_ONE;
        if (w_pop) r_rd_ptr <= r_rd_ptr + LP_ONE;
        r_count        <= w_count_nxt;
        r_almost_full  <= (w_count_nxt >= LP_AF);
        r_almost_empty <= (w_count_nxt <= LP_AE);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_writeData;
  end

  assign o_writeReady  = !w_full;
  assign o_readValid   = !w_empty;
  assign o_readData    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign o_fillCount   = r_count;
  assign o_almostFull  = r_almost_full;
  assign o_almostEmpty = r_almost_empty;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Single-clock, parametrised-width/-depth synchronous FIFO with a valid/ready handshake on both sides.
- First-word-fall-through read port, full-capacity storage (all 2^DEPTH_LOG2 entries usable).
- Fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Sits between pixel/command producers and the LCD output pipeline, where both ends share one clock domain.

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH_LOG2, 8: log2 of entry count; depth = 2^DEPTH_LOG2 (256).
- ALMOST_FULL_LEVEL, 240: o_almostFull asserted when fill count >= this value.
- ALMOST_EMPTY_LEVEL, 16: o_almostEmpty asserted when fill count <= this value.

Ports:
- i_clock  in  1  rising-edge clock for all logic.
- i_nReset  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous clear of pointers, count and flags.
- i_clearErrors  in  1  synchronous clear of the sticky error flags.
- i_writeData  in  WIDTH  write data.
- i_writeValid  in  1  producer offers i_writeData.
- o_writeReady  out  1  FIFO can accept a word (not full).
- o_readData  out  WIDTH  head-of-FIFO word.
- o_readValid  out  1  o_readData holds a valid word (not empty).
- i_readReady  in  1  consumer takes o_readData.
- o_fillCount  out  DEPTH_LOG2+1  number of stored words, 0..2^DEPTH_LOG2.
- o_almostFull  out  1  fill >= ALMOST_FULL_LEVEL.
- o_almostEmpty  out  1  fill <= ALMOST_EMPTY_LEVEL.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (i_nReset=0, asynchronous):
  - Read/write pointers and count = 0.
  - o_readValid=0, o_writeReady=1, o_fillCount=0, o_almostEmpty=1.
  - o_almostFull=(ALMOST_FULL_LEVEL==0).
  - o_overflow=0, o_underflow=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words immediately.
- Pointers are DEPTH_LOG2+1 bits wide; the MSB disambiguates full from empty.
  - Empty: pointers equal.
  - Full: low bits equal and MSB differs.
  - Pointers wrap modulo 2^(DEPTH_LOG2+1).
- Write handshake:
  - A word is accepted on a rising edge when i_writeValid && o_writeReady.
  - Accepted data is written at the write pointer; the pointer increments.
  - o_writeReady = !full, derived from registered state only; it has no combinational path from i_readReady.
- Read handshake:
  - FWFT: o_readData = mem[read pointer] whenever o_readValid=1.
  - A pop occurs on a rising edge when o_readValid && i_readReady; the pointer increments.
  - o_readData is don't-care while o_readValid=0.
- Latency:
  - A word written into an empty FIFO appears with o_readValid=1 on the cycle after the accepting edge.
  - A pop from a full FIFO raises o_writeReady on the cycle after the popping edge.
- Simultaneous accept and pop in one cycle: count unchanged, both pointers advance.
  - When full: only the pop happens (write not accepted).
  - When empty: only the write happens (no pop).
- o_fillCount, o_almostFull and o_almostEmpty are registered and updated on the same edge as the pointers.
  - Count rules: +1 on accept-only, -1 on pop-only, unchanged otherwise.
- o_overflow sets on an edge where i_writeValid=1 and full; the word is dropped and FIFO state is unchanged.
- o_underflow sets on an edge where i_readReady=1 and empty; the pointer does not move.
- Both error flags hold until i_clearErrors=1 or reset.
  - If set and clear coincide, set wins.
- i_flush=1 on an edge:
  - Pointers/count go to 0 and flags take their reset values, except the error flags, which are preserved.
  - Flush overrides any accept/pop in the same cycle; the concurrent write is discarded and does not set o_overflow.

Test Plan:
- Reset, then write 0x00000001..0x00000003 on consecutive cycles with i_readReady=0 -> o_fillCount=3; o_readData=0x00000001 with o_readValid=1 one cycle after the first write.
- Fill 256 words (values 0..255) -> o_writeReady=0 and o_fillCount=256; o_almostFull goes high after word 240 is written.
  - Then drain all 256 -> read order 0..255 and o_readValid=0 at the end.
- Full FIFO with i_writeValid=1 for one cycle -> o_overflow=1, count stays 256, later reads contain no extra word.
  - Pulse i_clearErrors -> o_overflow=0.
- With 5 words stored, hold i_writeValid=1 and i_readReady=1 for 300 cycles on an incrementing pattern -> count stays 5, output sequence is in order with no gaps, pointers wrap.
- Empty FIFO with i_readReady=1 -> o_underflow=1, o_fillCount=0.
  - Then write 0xDEADBEEF with i_readReady=1 -> the word is popped on the cycle after it appears.
- With 10 words stored, assert i_flush together with i_writeValid=1 -> next cycle o_fillCount=0, o_readValid=0, o_almostEmpty=1.
  - Separately, assert i_nReset=0 mid-burst -> all outputs return to reset values without a clock edge.
